// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered one-hot/encoded grant,
// an optional per-grant hold limit, and one dead cycle between owners.
module rr_arbiter_4 #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] Req,
  output logic [3:0] Gnt,
  output logic [1:0] GntIdx,
  output logic       Busy,
  output logic       Timeout
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam bit       UNLIMITED = (MAX_HOLD == 0);
  localparam logic [7:0] HOLD_LIM = 8'(MAX_HOLD);

  state_t     state;
  logic [1:0] ptr;
  logic [1:0] own;
  logic [7:0] cnt;

  logic [2:0] win;
  logic       hold_ok;

  // Returns {found, index}; scans from p upward with wrap, lowest offset wins.
  function automatic logic [2:0] pick(input logic [3:0] req, input logic [1:0] p);
    logic [2:0] r;
    logic [1:0] idx;
    r = 3'b000;
    for (int i = 3; i >= 0; i--) begin
      idx = p + 2'(i);
      if (req[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  assign win     = pick(Req, ptr);
  assign hold_ok = UNLIMITED || (cnt < HOLD_LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= 2'd0;
      own     <= 2'd0;
      cnt     <= 8'd0;
      Gnt     <= 4'b0000;
      GntIdx  <= 2'd0;
      Busy    <= 1'b0;
      Timeout <= 1'b0;
    end else begin
      Timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (win[2]) begin
            state  <= GRANT;
            own    <= win[1:0];
            Gnt    <= 4'b0001 << win[1:0];
            GntIdx <= win[1:0];
            Busy   <= 1'b1;
            ptr    <= win[1:0] + 2'd1;
            cnt    <= 8'd1;
          end else begin
            state  <= IDLE;
            Gnt    <= 4'b0000;
            GntIdx <= 2'd0;
            Busy   <= 1'b0;
          end
        end
        GRANT: begin
          if (Req[own] && hold_ok) begin
            // Saturate so an unlimited hold never wraps back under the limit.
            if (cnt != 8'hFF) cnt <= cnt + 8'd1;
          end else begin
            state   <= GAP;
            Gnt     <= 4'b0000;
            GntIdx  <= 2'd0;
            Busy    <= 1'b0;
            Timeout <= Req[own];
          end
        end
        default: begin
          state  <= IDLE;
          Gnt    <= 4'b0000;
          GntIdx <= 2'd0;
          Busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule
